// File: rtl/fetch_responder_if.sv
// Fetch bus bundle: memory read channel plus the decode-side handshake.
// master = fetch_responder side, slave = memory/decode side.
interface fetch_responder_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pc_4;
  logic            misaligned;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    output instr_pc_4,
    output misaligned
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    input  instr_pc_4,
    input  misaligned
  );
endinterface

// File: rtl/fetch_responder.sv
// Instruction-fetch front end: samples pc/pc_4, reads imem via req/ack,
// hands the word to decode (valid/ready) and holds the PC via busy.
// Ports: clk, reset (sync, active-high), pc, pc_4, branch, busy,
//        bus (fetch_responder_if.master: mem_* and instr_* signals).
module fetch_responder #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_4,
  input  logic            branch,
  output logic            busy,
  fetch_responder_if.master bus
);

  typedef enum logic [1:0] {
    LAUNCH,
    REQ,
    FLUSH,
    VALID
  } state_t;

  state_t state;
  state_t state_nx;

  logic            req_q;
  logic            req_nx;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] addr_nx;
  logic            vld_q;
  logic            vld_nx;
  logic [XLEN-1:0] ins_q;
  logic [XLEN-1:0] ins_nx;
  logic [XLEN-1:0] ipc_q;
  logic [XLEN-1:0] ipc_nx;
  logic [XLEN-1:0] ipc4_q;
  logic [XLEN-1:0] ipc4_nx;
  logic            mis_q;
  logic            mis_nx;

  logic            pc_mis;
  logic [XLEN-1:0] nop_word;

  assign pc_mis   = |pc[1:0];
  assign nop_word = XLEN'(NOP_INSN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LAUNCH;
      req_q  <= 1'b0;
      addr_q <= '0;
      vld_q  <= 1'b0;
      ins_q  <= '0;
      ipc_q  <= '0;
      ipc4_q <= '0;
      mis_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      req_q  <= req_nx;
      addr_q <= addr_nx;
      vld_q  <= vld_nx;
      ins_q  <= ins_nx;
      ipc_q  <= ipc_nx;
      ipc4_q <= ipc4_nx;
      mis_q  <= mis_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LAUNCH: begin
        if (branch)      state_nx = LAUNCH;
        else if (pc_mis) state_nx = VALID;
        else             state_nx = REQ;
      end
      REQ: begin
        if (bus.mem_ack && !branch)     state_nx = VALID;
        else if (bus.mem_ack && branch) state_nx = LAUNCH;
        else if (branch)                state_nx = FLUSH;
        else                            state_nx = REQ;
      end
      FLUSH: begin
        // request stays up until memory answers; data is dropped
        if (bus.mem_ack) state_nx = LAUNCH;
      end
      VALID: begin
        if (branch || bus.instr_ready) state_nx = LAUNCH;
      end
      default: state_nx = LAUNCH;
    endcase
  end

  always_comb begin
    req_nx  = req_q;
    addr_nx = addr_q;
    vld_nx  = vld_q;
    ins_nx  = ins_q;
    ipc_nx  = ipc_q;
    ipc4_nx = ipc4_q;
    mis_nx  = mis_q;
    busy    = 1'b1;
    unique case (state)
      LAUNCH: begin
        addr_nx = pc;
        ipc_nx  = pc;
        ipc4_nx = pc_4;
        mis_nx  = pc_mis && !branch;
        if (!branch && pc_mis) begin
          ins_nx = nop_word;
          vld_nx = 1'b1;
        end else if (!branch) begin
          req_nx = 1'b1;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          req_nx = 1'b0;
          if (!branch) begin
            ins_nx = bus.mem_rdata;
            vld_nx = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (bus.mem_ack) req_nx = 1'b0;
      end
      VALID: begin
        // PC may only advance when decode really takes the word
        busy = !(bus.instr_ready && !branch);
        if (branch || bus.instr_ready) vld_nx = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.mem_req     = req_q;
  assign bus.mem_addr    = addr_q;
  assign bus.instr_valid = vld_q;
  assign bus.instr       = ins_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_pc_4  = ipc4_q;
  assign bus.misaligned  = mis_q;

endmodule

// File: tb/tb_fetch_responder.sv
// Bench for fetch_responder: directed vector table plus a randomized
// run against a PC/memory/decode model at transaction level.
module tb_fetch_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic        branch;
  logic        busy;

  fetch_responder_if #(.XLEN(32)) bus ();

  assign pc_4 = pc + 32'd4;

  fetch_responder #(
    .XLEN(32),
    .NOP_INSN(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pc(pc),
    .pc_4(pc_4),
    .branch(branch),
    .busy(busy),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm,
                       input logic [130:0] act,
                       input logic [130:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        br;
    logic        ack;
    logic [31:0] rd;
    logic        rdy;
    logic        cb;
    logic        bsy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic        mis;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    logic rst, logic [31:0] p, logic br, logic ack,
    logic [31:0] rd, logic rdy, logic cb, logic bsy,
    logic req, logic [31:0] addr, logic vld,
    logic [31:0] ins, logic [31:0] ipc,
    logic [31:0] ipc4, logic mis);
    vec_t v;
    v.rst = rst; v.pc = p; v.br = br; v.ack = ack;
    v.rd = rd; v.rdy = rdy; v.cb = cb; v.bsy = bsy;
    v.req = req; v.addr = addr; v.vld = vld;
    v.ins = ins; v.ipc = ipc; v.ipc4 = ipc4; v.mis = mis;
    return v;
  endfunction

  function automatic logic [31:0] word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  function automatic logic [130:0] outs();
    return {bus.mem_req, bus.mem_addr, bus.instr_valid,
            bus.instr, bus.instr_pc, bus.instr_pc_4,
            bus.misaligned};
  endfunction

  logic [31:0] nxt;
  logic [31:0] tgt;
  logic [31:0] p_addr;
  logic        p_req;
  logic        p_ack;
  logic        p_rst;
  logic        r;
  logic        acc;
  int          cnt;
  int          n_acc;

  initial begin
    reset = 1'b1;
    pc = '0;
    branch = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    bus.instr_ready = 1'b0;

    // reset, then fetch at 0 with one-cycle ack and ready decode
    vq.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,1, 1,1, 1,0,0,0,0,4,0));
    vq.push_back(mk(0,0,0,1,32'h00500093,1, 1,1,
                    0,0,1,32'h00500093,0,4,0));
    vq.push_back(mk(0,0,0,0,0,1, 1,0,
                    0,0,0,32'h00500093,0,4,0));
    vq.push_back(mk(0,4,0,0,0,0, 1,1,
                    1,4,0,32'h00500093,4,8,0));
    // decode stalls 5 cycles
    vq.push_back(mk(0,4,0,1,32'hAAAA0001,0, 1,1,
                    0,4,1,32'hAAAA0001,4,8,0));
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(0,4,0,0,0,0, 1,1,
                      0,4,1,32'hAAAA0001,4,8,0));
    vq.push_back(mk(0,4,0,0,0,1, 1,0,
                    0,4,0,32'hAAAA0001,4,8,0));
    // branch in REQ two cycles before ack -> FLUSH
    vq.push_back(mk(0,8,0,0,0,0, 1,1,
                    1,8,0,32'hAAAA0001,8,12,0));
    vq.push_back(mk(0,8,1,0,0,0, 1,1,
                    1,8,0,32'hAAAA0001,8,12,0));
    vq.push_back(mk(0,32'h40,0,0,0,0, 1,1,
                    1,8,0,32'hAAAA0001,8,12,0));
    vq.push_back(mk(0,32'h40,0,1,32'hDEAD0000,1, 1,1,
                    0,8,0,32'hAAAA0001,8,12,0));
    vq.push_back(mk(0,32'h40,0,0,0,0, 1,1,
                    1,32'h40,0,32'hAAAA0001,32'h40,32'h44,0));
    // branch coincident with ack
    vq.push_back(mk(0,32'h40,1,1,32'hBEEF0000,1, 1,1,
                    0,32'h40,0,32'hAAAA0001,32'h40,32'h44,0));
    vq.push_back(mk(0,32'h80,0,0,0,0, 1,1,
                    1,32'h80,0,32'hAAAA0001,32'h80,32'h84,0));
    vq.push_back(mk(0,32'h80,0,1,32'h11111111,0, 1,1,
                    0,32'h80,1,32'h11111111,32'h80,32'h84,0));
    // branch while valid: not consumed, busy stays high
    vq.push_back(mk(0,32'h80,1,0,0,1, 1,1,
                    0,32'h80,0,32'h11111111,32'h80,32'h84,0));
    // misaligned pc -> NOP, no request
    vq.push_back(mk(0,6,0,0,0,0, 1,1,
                    0,6,1,NOP,6,32'hA,1));
    vq.push_back(mk(0,6,0,0,0,1, 1,0,
                    0,6,0,NOP,6,32'hA,1));
    // spurious ack in LAUNCH, FLUSH, then reset in FLUSH
    vq.push_back(mk(0,12,0,1,32'h99999999,0, 1,1,
                    1,12,0,NOP,12,16,0));
    vq.push_back(mk(0,12,1,0,0,0, 1,1,
                    1,12,0,NOP,12,16,0));
    vq.push_back(mk(1,32'h100,0,0,0,0, 1,1,
                    0,0,0,0,0,0,0));
    vq.push_back(mk(0,32'h100,0,1,32'h77777777,0, 1,1,
                    1,32'h100,0,0,32'h100,32'h104,0));
    vq.push_back(mk(0,32'h100,0,1,32'h22222222,0, 1,1,
                    0,32'h100,1,32'h22222222,32'h100,32'h104,0));
    vq.push_back(mk(0,32'h100,0,0,0,1, 1,0,
                    0,32'h100,0,32'h22222222,32'h100,32'h104,0));
    // pc_4 wrap, slow ack, spurious ack in VALID
    vq.push_back(mk(0,32'hFFFFFFFC,0,0,0,0, 1,1,
                    1,32'hFFFFFFFC,0,32'h22222222,32'hFFFFFFFC,0,0));
    vq.push_back(mk(0,32'hFFFFFFFC,0,0,0,0, 1,1,
                    1,32'hFFFFFFFC,0,32'h22222222,32'hFFFFFFFC,0,0));
    vq.push_back(mk(0,32'hFFFFFFFC,0,1,32'h33,0, 1,1,
                    0,32'hFFFFFFFC,1,32'h33,32'hFFFFFFFC,0,0));
    vq.push_back(mk(0,32'hFFFFFFFC,0,1,32'h44,0, 1,1,
                    0,32'hFFFFFFFC,1,32'h33,32'hFFFFFFFC,0,0));
    vq.push_back(mk(0,32'hFFFFFFFC,0,0,0,1, 1,0,
                    0,32'hFFFFFFFC,0,32'h33,32'hFFFFFFFC,0,0));
    // branch in LAUNCH: recapture next cycle
    vq.push_back(mk(0,0,1,0,0,0, 1,1,
                    0,0,0,32'h33,0,4,0));
    vq.push_back(mk(0,32'h20,0,0,0,0, 1,1,
                    1,32'h20,0,32'h33,32'h20,32'h24,0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset = vq[i].rst;
      pc = vq[i].pc;
      branch = vq[i].br;
      bus.mem_ack = vq[i].ack;
      bus.mem_rdata = vq[i].rd;
      bus.instr_ready = vq[i].rdy;
      #1;
      if (vq[i].cb)
        check($sformatf("row%0d busy", i), 131'(busy),
              131'(vq[i].bsy));
      @(posedge clk);
      #1;
      check($sformatf("row%0d outs", i), outs(),
            {vq[i].req, vq[i].addr, vq[i].vld, vq[i].ins,
             vq[i].ipc, vq[i].ipc4, vq[i].mis});
    end

    // randomized run: PC, memory and decode modelled here
    cnt = 0;
    n_acc = 0;
    p_req = 0; p_ack = 0; p_rst = 1; p_addr = '0;
    pc = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c > 0) begin
        if (p_rst)
          check("rand reset", outs(), '0);
        else if (p_req && !p_ack)
          check("req hold", 131'({bus.mem_req, bus.mem_addr}),
                131'({1'b1, p_addr}));
        else if (p_req && p_ack)
          check("req drop", 131'(bus.mem_req), '0);
      end
      bus.mem_ack = 1'b0;
      bus.mem_rdata = $urandom;
      if (bus.mem_req) begin
        if (cnt == 0) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = word(bus.mem_addr);
          cnt = $urandom_range(0, 3);
        end else begin
          cnt--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus.mem_ack = 1'b1;
      end
      r = (c < 2) || ($urandom_range(0, 249) == 0);
      reset = r;
      branch = !r && ($urandom_range(0, 9) == 0);
      tgt = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      if ($urandom_range(0, 5) == 0) tgt[1] = 1'b1;
      bus.instr_ready = !r && ($urandom_range(0, 2) != 0);
      #1;
      acc = bus.instr_valid && bus.instr_ready && !branch;
      if (!r)
        check("rand busy", 131'(busy), 131'(!acc));
      if (!r && acc) begin
        n_acc++;
        check("rand accept",
              131'({bus.instr, bus.instr_pc, bus.instr_pc_4,
                    bus.misaligned}),
              131'({(|pc[1:0]) ? NOP : word(pc), pc, pc + 32'd4,
                    |pc[1:0]}));
      end
      if (r)           nxt = 32'h1000;
      else if (branch) nxt = tgt;
      else if (acc)    nxt = pc + 32'd4;
      else             nxt = pc;
      p_req = bus.mem_req;
      p_ack = bus.mem_ack;
      p_addr = bus.mem_addr;
      p_rst = r;
      @(posedge clk);
      #1;
      pc = nxt;
    end
    check("rand progress", 131'(n_acc > 100), 131'(1));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
